sm_split: RTL and testbench
===========================

# sm_split

Stimulus generator for the three-beat summing accumulator. It accepts one 7-bit target total through a valid/ready handshake and emits exactly three `o_dval` beats. Each beat carries two 4-bit lanes. The downstream accumulator sums all six lanes of the three beats and reproduces the target. The block sits on the input side of the accumulator in the protocol-verify bench and drives its `i_dval`/`i[2]` interface directly. It has an optional inter-beat gap so the accumulator's hold path gets exercised.

## Interface
- `GAP`, default 0: idle cycles inserted between consecutive beats of one group. Legal range is 0..15.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `i_dval`  input  1  target valid.
- `i_val`  input  7  target total, unsigned.
- `o_rdy`  output  1  block can accept a target this cycle.
- `o_dval`  output  1  beat valid; connects to the accumulator's `i_dval`.
- `o`  output  4 x [2] (unpacked array of two 4-bit lanes)  beat lanes; connects to the accumulator's `i`.
- `o_err`  output  1  one-cycle pulse: the last accepted target was out of range.

## Operation
- **States**
  - IDLE: `o_rdy=1`.
  - SEND: a beat is presented.
  - WAIT: gap cycles between beats.
- **Accept**
  - A target is accepted on a rising edge where `i_dval && o_rdy`.
  - `i_val` is ignored on any edge without an accept.
- **Range check**
  - A target is legal when `i_val <= 90` (90 = 3 beats x 2 lanes x 15).
  - An illegal accept sends no beats. `o_err` pulses for one cycle, and the state stays IDLE, so `o_rdy` stays 1.
- **Split rule**
  - The split is greedy and deterministic, lane 0 first.
  - A 7-bit remainder register `rem` is loaded with `i_val` on accept.
  - Per beat: `lane0 = min(rem,15)`, then `rem -= lane0`; `lane1 = min(rem,15)`, then `rem -= lane1`.
  - After beat 3, `rem` is always 0.
- **Beat counter**
  - 2-bit, counts 0..2. A gap counter of 4 bits runs during WAIT.
- **Transitions**
  - IDLE, legal accept → SEND (beat 0).
  - SEND, beat < 2, GAP > 0 → WAIT.
  - SEND, beat < 2, GAP = 0 → SEND (next beat).
  - WAIT, after GAP cycles → SEND.
  - SEND, beat = 2 → IDLE, or SEND (beat 0 of a new target) if a legal accept occurs on that edge.
- **Registered outputs**
  - `o_dval`, `o`, `o_err` are registered.
  - `o` is `{0,0}` whenever `o_dval=0`.
- **`o_rdy`**
  - Combinational, from state.
  - High in IDLE, and also during the beat-2 SEND cycle, so groups can run back-to-back.
- **Reset**
  - `rst=1` aborts any group in progress, with no further beats.
  - Registered values: state=IDLE, `rem=0`, counters=0, `o_dval=0`, `o={0,0}`, `o_err=0`.
  - `o_rdy` reads 1 in the first cycle after reset releases.
  - If `rst` and `i_dval` are high on the same edge, reset wins and the target is dropped.

## Timing
- For an accept on edge E, `o_dval=1` during the cycles starting at edges:
  - E+1
  - E+2+GAP
  - E+3+2·GAP
- `o_dval` is 0 in all other cycles of the group.
- `o_err` is high for exactly the one cycle after an illegal accept.
- `o_err` and `o_dval` are never high together.
- Throughput with GAP=0 is one target per 3 cycles: `o_dval` stays continuously high across back-to-back groups.
- The accumulator's result appears one cycle after the beat-3 cycle.

## Test plan
- GAP=0, target 37:
  - Beats (15,15), (7,0), (0,0) in three consecutive cycles starting the cycle after accept.
  - The attached accumulator outputs `o=37` with `o_dval=1` one cycle later.
- GAP=0, targets 90 then 0 back-to-back (second accept during the beat-2 cycle):
  - Six consecutive beats: (15,15)x3, then (0,0)x3.
  - Accumulator outputs 90 and then 0, three cycles apart.
- Target 91, then 127:
  - Each accept gives one `o_err` pulse and no `o_dval`.
  - `o_rdy` stays 1 throughout.
  - A following legal target 5 gives beats (5,0), (0,0), (0,0).
- GAP=3, target 46:
  - Beats (15,15), (15,1), (0,0) at cycles +1, +5, +9 after accept.
  - `o_rdy` is 0 from +1 through +8 and 1 again at +9.
  - Accumulator outputs 46.
- Reset mid-group (GAP=2, target 60, `rst` high one cycle after beat 1):
  - No further beats; all outputs 0 and `o_rdy` 1 in the cycle after reset releases.
  - A new target 12 then yields (12,0), (0,0), (0,0).
- `i_dval` held high continuously with random legal targets, GAP random 0..15:
  - Accumulator outputs match accepted targets in order.
  - `rem` is 0 after every third beat.

Source files
------------

// File: rtl/sm_split.sv
// sm_split: splits one 7-bit target total into three beats of two 4-bit lanes.
// Greedy split, lane 0 first, with an optional idle gap between beats.
module sm_split #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_dval,
  input  logic [6:0] i_val,
  output logic       o_rdy,
  output logic       o_dval,
  output logic [3:0] o [2],
  output logic       o_err
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  state_t     state, state_n;
  logic [1:0] beat, beat_n;
  logic [3:0] gap_cnt, gap_n;
  logic [6:0] rem;

  logic       accept, legal, start, load;
  logic [6:0] src, r1, r2;
  logic [3:0] l0, l1;

  assign o_rdy  = (state == IDLE) ||
                  (state == SEND && beat == 2'd2);
  assign accept = i_dval && o_rdy;
  assign legal  = (i_val <= 7'd90);
  assign start  = accept && legal;

  always_comb begin
    state_n = state;
    beat_n  = beat;
    gap_n   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          beat_n  = 2'd0;
        end
      end
      SEND: begin
        if (beat == 2'd2) begin
          state_n = start ? SEND : IDLE;
          beat_n  = 2'd0;
        end else if (GAP == 0) begin
          beat_n = beat + 2'd1;
        end else begin
          state_n = WAIT;
          gap_n   = 4'd0;
        end
      end
      WAIT: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = SEND;
          beat_n  = beat + 2'd1;
        end else begin
          gap_n = gap_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // a fresh target feeds the split directly; otherwise continue from rem
  always_comb begin
    src = start ? i_val : rem;
    l0  = (src > 7'd15) ? 4'd15 : src[3:0];
    r1  = src - {3'b000, l0};
    l1  = (r1 > 7'd15) ? 4'd15 : r1[3:0];
    r2  = r1 - {3'b000, l1};
  end

  assign load = (state_n == SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= 2'd0;
      gap_cnt <= 4'd0;
      rem     <= 7'd0;
      o_dval  <= 1'b0;
      o[0]    <= 4'd0;
      o[1]    <= 4'd0;
      o_err   <= 1'b0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      gap_cnt <= gap_n;
      o_err   <= accept && !legal;
      o_dval  <= load;
      if (load) begin
        o[0] <= l0;
        o[1] <= l1;
        rem  <= r2;
      end else begin
        o[0] <= 4'd0;
        o[1] <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_sm_split.sv
// tb_sm_split: directed and random checks of sm_split at GAP 0, 2, 3, 15.
// A small accumulator model sums every three beats against accepted targets.
module tb_sm_split;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_dval [N];
  logic [6:0] i_val  [N];
  logic       o_rdy  [N];
  logic       o_dval [N];
  logic       o_err  [N];
  logic [3:0] l0     [N];
  logic [3:0] l1     [N];

  int checks = 0;
  int passed = 0;

  int acc_sum [N];
  int acc_n   [N];
  int exp_q   [N][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int G = (g == 0) ? 0 :
                       (g == 1) ? 2 :
                       (g == 2) ? 3 : 15;
    logic [3:0] ob [2];
    sm_split #(.GAP(G)) u (
      .clk    (clk),
      .rst    (rst),
      .i_dval (i_dval[g]),
      .i_val  (i_val[g]),
      .o_rdy  (o_rdy[g]),
      .o_dval (o_dval[g]),
      .o      (ob),
      .o_err  (o_err[g])
    );
    assign l0[g] = ob[0];
    assign l1[g] = ob[1];
  end

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(int d, string tag, int dv, int a, int b);
    check({tag, ".dval"}, int'(o_dval[d]), dv);
    check({tag, ".l0"}, int'(l0[d]), a);
    check({tag, ".l1"}, int'(l1[d]), b);
  endtask

  // expected totals: every legal accepted target, in order
  always @(posedge clk) begin
    for (int d = 0; d < N; d++)
      if (!rst && i_dval[d] && o_rdy[d] && i_val[d] <= 7'd90)
        exp_q[d].push_back(int'(i_val[d]));
  end

  // accumulator model: sums six lanes over three beats
  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (rst) begin
        acc_sum[d] = 0;
        acc_n[d]   = 0;
        exp_q[d].delete();
      end else if (o_dval[d]) begin
        check($sformatf("excl%0d", d), int'(o_err[d]), 0);
        acc_sum[d] += int'(l0[d]) + int'(l1[d]);
        acc_n[d]++;
        if (acc_n[d] == 3) begin
          check($sformatf("acc%0d", d), acc_sum[d],
                (exp_q[d].size() > 0) ? exp_q[d].pop_front() : -1);
          acc_sum[d] = 0;
          acc_n[d]   = 0;
        end
      end else begin
        check($sformatf("zero%0d", d), int'(l0[d]) + int'(l1[d]), 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < N; d++) begin
      i_dval[d] = 1'b0;
      i_val[d]  = 7'd0;
    end
    tick();
    // target offered during reset must be dropped
    i_dval[0] = 1'b1;
    i_val[0]  = 7'd20;
    tick();
    i_dval[0] = 1'b0;
    rst = 1'b0;
    for (int d = 0; d < N; d++) begin
      check("rst.rdy", int'(o_rdy[d]), 1);
      check("rst.dval", int'(o_dval[d]), 0);
      check("rst.err", int'(o_err[d]), 0);
    end
    tick();
    check("rst.drop", int'(o_dval[0]), 0);

    // GAP=0, target 37
    i_dval[0] = 1'b1;
    i_val[0]  = 7'd37;
    tick();
    i_dval[0] = 1'b0;
    i_val[0]  = 7'd99;
    beat(0, "t37.b0", 1, 15, 15);
    check("t37.rdy0", int'(o_rdy[0]), 0);
    tick();
    beat(0, "t37.b1", 1, 7, 0);
    tick();
    beat(0, "t37.b2", 1, 0, 0);
    check("t37.rdy2", int'(o_rdy[0]), 1);
    tick();
    beat(0, "t37.end", 0, 0, 0);

    // GAP=0, 90 then 0 back-to-back
    i_dval[0] = 1'b1;
    i_val[0]  = 7'd90;
    tick();
    i_val[0] = 7'd0;
    beat(0, "bb.b0", 1, 15, 15);
    check("bb.rdy0", int'(o_rdy[0]), 0);
    tick();
    beat(0, "bb.b1", 1, 15, 15);
    check("bb.rdy1", int'(o_rdy[0]), 0);
    tick();
    beat(0, "bb.b2", 1, 15, 15);
    check("bb.rdy2", int'(o_rdy[0]), 1);
    tick();
    i_dval[0] = 1'b0;
    beat(0, "bb.b3", 1, 0, 0);
    check("bb.rdy3", int'(o_rdy[0]), 0);
    tick();
    beat(0, "bb.b4", 1, 0, 0);
    tick();
    beat(0, "bb.b5", 1, 0, 0);
    tick();
    beat(0, "bb.end", 0, 0, 0);

    // out-of-range targets 91 and 127, then 5
    i_dval[0] = 1'b1;
    i_val[0]  = 7'd91;
    tick();
    check("e91.err", int'(o_err[0]), 1);
    check("e91.dval", int'(o_dval[0]), 0);
    check("e91.rdy", int'(o_rdy[0]), 1);
    i_val[0] = 7'd127;
    tick();
    check("e127.err", int'(o_err[0]), 1);
    check("e127.dval", int'(o_dval[0]), 0);
    check("e127.rdy", int'(o_rdy[0]), 1);
    i_dval[0] = 1'b0;
    tick();
    check("e.clr", int'(o_err[0]), 0);
    check("e.rdy", int'(o_rdy[0]), 1);
    i_dval[0] = 1'b1;
    i_val[0]  = 7'd5;
    tick();
    i_dval[0] = 1'b0;
    beat(0, "t5.b0", 1, 5, 0);
    tick();
    beat(0, "t5.b1", 1, 0, 0);
    tick();
    beat(0, "t5.b2", 1, 0, 0);
    tick();
    beat(0, "t5.end", 0, 0, 0);

    // GAP=3, target 46
    i_dval[2] = 1'b1;
    i_val[2]  = 7'd46;
    tick();
    i_dval[2] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      automatic int dv = (k == 1 || k == 5 || k == 9) ? 1 : 0;
      automatic int a  = (k == 1 || k == 5) ? 15 : 0;
      automatic int b  = (k == 1) ? 15 : (k == 5) ? 1 : 0;
      beat(2, $sformatf("g3.k%0d", k), dv, a, b);
      check($sformatf("g3.rdy%0d", k), int'(o_rdy[2]), (k == 9) ? 1 : 0);
      if (k < 9) tick();
    end
    tick();
    beat(2, "g3.end", 0, 0, 0);
    check("g3.rdyend", int'(o_rdy[2]), 1);

    // GAP=2, target 60, reset after beat 1
    i_dval[1] = 1'b1;
    i_val[1]  = 7'd60;
    tick();
    i_dval[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      beat(1, $sformatf("r60.k%0d", k),
           (k == 1 || k == 4) ? 1 : 0,
           (k == 1 || k == 4) ? 15 : 0,
           (k == 1 || k == 4) ? 15 : 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat(1, "r60.rst", 0, 0, 0);
    check("r60.err", int'(o_err[1]), 0);
    check("r60.rdy", int'(o_rdy[1]), 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("r60.quiet%0d", k), int'(o_dval[1]), 0);
    end
    i_dval[1] = 1'b1;
    i_val[1]  = 7'd12;
    tick();
    i_dval[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      beat(1, $sformatf("t12.k%0d", k),
           (k == 1 || k == 4 || k == 7) ? 1 : 0,
           (k == 1) ? 12 : 0, 0);
      tick();
    end

    // i_dval held high with random legal targets on every GAP
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < 120; c++) begin
        i_dval[d] = 1'b1;
        i_val[d]  = 7'($urandom_range(0, 90));
        tick();
      end
      i_dval[d] = 1'b0;
      repeat (60) tick();
      check($sformatf("drain%0d", d), exp_q[d].size(), 0);
      check($sformatf("part%0d", d), acc_n[d], 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
